mux_rr_nx1: RTL and testbench
=============================

Name: mux_rr_nx1

Overview:
- Parametrised N-to-1 channel multiplexer; next generation of the 2x1 L2 mux.
- Generalises data width and channel count.
- Adds a round-robin mode alongside fixed selector mode, a valid/ready handshake on every input and on the output, and a registered output stage with channel tag.
- Sits between per-lane sources and a single downstream consumer in the PCI datapath.

Parameters:
DATA_W, 8, width of each data bus
NUM_CH, 4, number of input channels (legal 2..8)
SEL_W, $clog2(NUM_CH), width of selector and channel tag

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
dataIn  input  NUM_CH*DATA_W  packed channel data; channel i at [i*DATA_W +: DATA_W]
validIn  input  NUM_CH  per-channel valid
readyOut  output  NUM_CH  per-channel ready; one-hot or zero, combinational
mode  input  1  0 = fixed selector, 1 = round robin
selector  input  SEL_W  channel chosen in fixed mode
dataOut  output  DATA_W  registered output data
chOut  output  SEL_W  registered channel tag of dataOut
validOut  output  1  registered output valid
readyIn  input  1  downstream ready

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous-safe release):
  - dataOut=0, chOut=0, validOut=0.
  - RR pointer lastGnt=NUM_CH-1, so the first RR search starts at channel 0.
  - readyOut=0 while reset is low.
- Transfers:
  - Output transfer occurs when validOut && readyIn.
  - Input transfer on channel i occurs when validIn[i] && readyOut[i].
- loadEn = !validOut || readyIn. When loadEn=0, all readyOut=0 and the output registers hold.
- Grant (combinational, only when loadEn=1):
  - mode=0: grant channel selector if validIn[selector]=1. Otherwise no grant.
  - mode=0, selector >= NUM_CH: never grants.
  - mode=1: search channels lastGnt+1, lastGnt+2, ... with wrap-around mod NUM_CH. Grant the first with validIn=1. No grant if all validIn=0.
- On grant g:
  - readyOut[g]=1 and all other readyOut bits are 0.
  - Next edge: dataOut<=dataIn[g], chOut<=g, validOut<=1.
  - If mode=1, lastGnt<=g.
- On no grant with loadEn=1: validOut<=0 next edge. dataOut and chOut hold their last values.
- Latency: 1 cycle input-to-output.
- Throughput: 1 word/cycle when readyIn is held high (simultaneous output pop and reload in the same cycle).
- lastGnt:
  - Updates only on RR-mode grants.
  - Retained across mode switches.
  - A mode change takes effect in the same cycle's grant decision; there is no pipeline flush.
- Sources must not make validIn depend on readyOut. Once validIn is asserted, data must be held until the transfer occurs.
- Reset mid-operation: any in-flight word in the output register is discarded. validOut falls immediately (asynchronous).
- Backpressure: while readyIn=0 and validOut=1, dataOut, chOut and validOut are stable and no input is accepted.

Test Plan:
1. Reset hold, then release with all validIn=0 -> validOut=0, readyOut=0000, dataOut=0 for 5 cycles.
2. NUM_CH=4, mode=1, all validIn=1 with dataIn ch0..3 = 0x10,0x11,0x12,0x13, readyIn=1 -> chOut sequence 0,1,2,3,0,1,... and dataOut matches, one per cycle after 1-cycle latency.
3. mode=1, validIn=0101 -> grants alternate ch0, ch2, ch0.... Then drop ch2 valid -> ch0 granted every cycle.
4. mode=0, selector=2, validIn=1111, dataIn[2]=0xA5 -> only readyOut[2] asserts; dataOut=0xA5, chOut=2 continuously. Set selector=3 with validIn[3]=0 -> validOut=0 next cycle.
5. Backpressure: validOut=1 with dataOut=0x11, readyIn=0 for 4 cycles -> outputs frozen and readyOut=0000. readyIn=1 -> next word loads on the same edge the old word pops.
6. Assert reset mid-stream with validOut=1 -> validOut=0 immediately. After release in mode=1, the first grant is ch0 regardless of the pre-reset pointer.

Source files
------------

// File: rtl/mux_rr_nx1.sv
// N-to-1 valid/ready channel mux with fixed-selector and round-robin
// arbitration feeding a registered, channel-tagged output stage.
module mux_rr_nx1 #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] dataIn,
  input  logic [NUM_CH-1:0]        validIn,
  output logic [NUM_CH-1:0]        readyOut,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         selector,
  output logic [DATA_W-1:0]        dataOut,
  output logic [SEL_W-1:0]         chOut,
  output logic                     validOut,
  input  logic                     readyIn
);

  localparam logic [SEL_W:0] NUM_CH_W =
    (SEL_W+1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH =
    SEL_W'(NUM_CH-1);

  logic [DATA_W-1:0] ch_data [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = dataIn[i*DATA_W +: DATA_W];
  end

  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  ch_q, ch_d;
  logic              vld_q, vld_d;
  logic [SEL_W-1:0]  last_q, last_d;

  logic              load_en;
  logic              sel_ok;
  logic              fx_hit;
  logic              rr_hit;
  logic [SEL_W-1:0]  rr_idx;
  logic              gnt_any;
  logic [SEL_W-1:0]  gnt_idx;

  assign load_en = !vld_q || readyIn;

  // Out-of-range selectors (non-power-of-two NUM_CH) never grant.
  assign sel_ok = {1'b0, selector} < NUM_CH_W;
  assign fx_hit = sel_ok && validIn[selector];

  // Search starts one past the last RR winner and wraps.
  always_comb begin
    int cand;
    logic [SEL_W-1:0] cand_s;
    rr_hit = 1'b0;
    rr_idx = '0;
    cand   = 0;
    cand_s = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = int'(last_q) + k;
      if (cand >= NUM_CH) begin
        cand = cand - NUM_CH;
      end
      cand_s = SEL_W'(cand);
      if (!rr_hit && validIn[cand_s]) begin
        rr_hit = 1'b1;
        rr_idx = cand_s;
      end
    end
  end

  assign gnt_any = load_en && (mode ? rr_hit : fx_hit);
  assign gnt_idx = mode ? rr_idx : selector;

  always_comb begin
    readyOut = '0;
    if (reset && gnt_any) begin
      readyOut[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    vld_d  = vld_q;
    last_d = last_q;
    if (load_en) begin
      vld_d = gnt_any;
      if (gnt_any) begin
        data_d = ch_data[gnt_idx];
        ch_d   = gnt_idx;
        if (mode) begin
          last_d = gnt_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
      ch_q   <= '0;
      vld_q  <= 1'b0;
      last_q <= LAST_CH;
    end else begin
      data_q <= data_d;
      ch_q   <= ch_d;
      vld_q  <= vld_d;
      last_q <= last_d;
    end
  end

  assign dataOut  = data_q;
  assign chOut    = ch_q;
  assign validOut = vld_q;

endmodule

// File: tb/tb_mux_rr_nx1.sv
// Scoreboard bench for mux_rr_nx1: directed vectors push expected
// output words; a negedge monitor pops them on each output transfer.
module tb_mux_rr_nx1;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int SW = 2;

  logic          clk;
  logic          reset;
  logic [NC*DW-1:0] dataIn;
  logic [NC-1:0] validIn;
  logic [NC-1:0] readyOut;
  logic          mode;
  logic [SW-1:0] selector;
  logic [DW-1:0] dataOut;
  logic [SW-1:0] chOut;
  logic          validOut;
  logic          readyIn;

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [DW-1:0] d;
  } exp_t;

  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  mux_rr_nx1 #(
    .DATA_W(DW),
    .NUM_CH(NC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .dataIn  (dataIn),
    .validIn (validIn),
    .readyOut(readyOut),
    .mode    (mode),
    .selector(selector),
    .dataOut (dataOut),
    .chOut   (chOut),
    .validOut(validOut),
    .readyIn (readyIn)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h",
               nm, act, exp);
    end
  endtask

  task automatic push(
    input logic [SW-1:0] c,
    input logic [DW-1:0] d
  );
    exp_t e;
    e.ch = c;
    e.d  = d;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_cyc(
    input string         nm,
    input logic [NC-1:0] rdy
  );
    @(negedge clk);
    chk(nm, 32'(readyOut), 32'(rdy));
    tick();
  endtask

  task automatic set_data(
    input logic [DW-1:0] d0,
    input logic [DW-1:0] d1,
    input logic [DW-1:0] d2,
    input logic [DW-1:0] d3
  );
    dataIn = {d3, d2, d1, d0};
  endtask

  // Monitor: every output transfer must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && validOut && readyIn) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_unexpected: got ch %0d data %0h required none",
                   chOut, dataOut);
        end else begin
          e = sb.pop_front();
          chk("out_ch", 32'(chOut), 32'(e.ch));
          chk("out_data", 32'(dataOut), 32'(e.d));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    dataIn   = '0;
    validIn  = '0;
    mode     = 1'b1;
    selector = '0;
    readyIn  = 1'b1;
    #1;
    // 1: reset gating and idle after release
    reset   = 1'b0;
    validIn = 4'hF;
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    tick();
    @(negedge clk);
    chk("rst_validOut", 32'(validOut), 0);
    chk("rst_readyOut", 32'(readyOut), 0);
    chk("rst_dataOut", 32'(dataOut), 0);
    chk("rst_chOut", 32'(chOut), 0);
    validIn = '0;
    tick();
    reset = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("idle_validOut", 32'(validOut), 0);
      chk("idle_readyOut", 32'(readyOut), 0);
      chk("idle_dataOut", 32'(dataOut), 0);
      tick();
    end

    // 2: round robin over all four channels
    mode    = 1'b1;
    validIn = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      push(SW'(i % 4), 8'(8'h10 + i % 4));
      grant_cyc("t2_ready", 4'(1 << (i % 4)));
    end

    // 3: sparse valids, then a single valid
    validIn = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (i % 2 == 1) ? 2 : 0;
      push(SW'(c), 8'(8'h10 + c));
      grant_cyc("t3_alt", 4'(1 << c));
    end
    validIn = 4'b0001;
    repeat (3) begin
      push(2'd0, 8'h10);
      grant_cyc("t3_solo", 4'b0001);
    end

    // 4: fixed selector
    mode     = 1'b0;
    selector = 2'd2;
    validIn  = 4'b1111;
    set_data(8'h10, 8'h11, 8'hA5, 8'h13);
    repeat (4) begin
      push(2'd2, 8'hA5);
      grant_cyc("t4_fixed", 4'b0100);
    end
    selector = 2'd3;
    validIn  = 4'b0111;
    grant_cyc("t4_nogrant", 4'b0000);
    @(negedge clk);
    chk("t4_validOut", 32'(validOut), 0);
    chk("t4_chOut_hold", 32'(chOut), 2);
    chk("t4_dataOut_hold", 32'(dataOut), 32'hA5);
    tick();

    // 5: backpressure; RR pointer still at ch0
    mode    = 1'b1;
    validIn = 4'b0010;
    set_data(8'h10, 8'h11, 8'h12, 8'h33);
    push(2'd1, 8'h11);
    grant_cyc("t5_load", 4'b0010);
    readyIn = 1'b0;
    validIn = 4'b1000;
    repeat (4) begin
      @(negedge clk);
      chk("bp_validOut", 32'(validOut), 1);
      chk("bp_dataOut", 32'(dataOut), 32'h11);
      chk("bp_chOut", 32'(chOut), 1);
      chk("bp_readyOut", 32'(readyOut), 0);
      tick();
    end
    readyIn = 1'b1;
    push(2'd3, 8'h33);
    grant_cyc("t5_resume", 4'b1000);
    validIn = '0;
    grant_cyc("t5_drain", 4'b0000);

    // 6: reset mid-stream discards word and pointer
    set_data(8'h10, 8'h11, 8'h12, 8'h13);
    validIn = 4'b1111;
    push(2'd0, 8'h10);
    grant_cyc("t6_pre0", 4'b0001);
    grant_cyc("t6_pre1", 4'b0010);
    reset = 1'b0;
    #1;
    chk("t6_async_validOut", 32'(validOut), 0);
    chk("t6_rst_readyOut", 32'(readyOut), 0);
    tick();
    tick();
    reset = 1'b1;
    push(2'd0, 8'h10);
    grant_cyc("t6_first", 4'b0001);
    push(2'd1, 8'h11);
    grant_cyc("t6_second", 4'b0010);
    validIn = '0;
    grant_cyc("t6_drain", 4'b0000);
    grant_cyc("t6_idle", 4'b0000);
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
